// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: IDLE (grant/accept) -> EXEC (drive ALU,
// capture result) -> RESP (hold result until the granted requester takes it).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_op,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_op,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag,
  // responses
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag,
  output logic             rsp_err
);

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_MAX = 5'h06;  // highest legal opcode (NOR)

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;   // id of the requester served most recently
  logic             gnt_q, gnt_d;     // id of the requester currently in flight
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       op_q, op_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             flag_q, flag_d;

  logic             gnt_sel;
  logic             in_idle;
  logic             rsp_take;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [4:0]       sel_op;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  // Ready is also gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    gnt_sel    = 1'b0;
    in_idle    = (state_q == S_IDLE);
    if (req0_valid && req1_valid) begin
      gnt_sel = ~last_q;
    end else begin
      gnt_sel = req1_valid;
    end
    req0_ready = rst_n && in_idle && req0_valid && !gnt_sel;
    req1_ready = rst_n && in_idle && req1_valid && gnt_sel;
    sel_a      = gnt_sel ? req1_a  : req0_a;
    sel_b      = gnt_sel ? req1_b  : req0_b;
    sel_op     = gnt_sel ? req1_op : req0_op;
  end

  // Response channel: only the granted requester sees valid, and only its ready counts.
  always_comb begin
    rsp0_valid = (state_q == S_RESP) && !gnt_q;
    rsp1_valid = (state_q == S_RESP) && gnt_q;
    rsp_take   = gnt_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    rsp_data   = data_q;
    rsp_flag   = flag_q;
    rsp_err    = err_q;
  end

  // ALU drive: latched operands during EXEC, neutral NOP with zero operands otherwise.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_NOP;
    if (state_q == S_EXEC) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
  end

  // Next-state logic: accept in IDLE, capture ALU result in EXEC, release on handshake in RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    err_d   = err_q;
    data_d  = data_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = S_EXEC;
          gnt_d   = gnt_sel;
          a_d     = sel_a;
          b_d     = sel_b;
          if (sel_op > OP_MAX) begin
            // illegal opcodes run as NOP and are flagged back to the requester
            op_d  = OP_NOP;
            err_d = 1'b1;
          end else begin
            op_d  = sel_op;
            err_d = 1'b0;
          end
        end
      end
      S_EXEC: begin
        data_d  = alu_out;
        flag_d  = alu_flag;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_take) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      err_q   <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      err_q   <= err_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of grant order and ALU results.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [4:0]   alu_op;
  logic         alu_flag;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_flag, rsp_err;

  int           tests = 0;
  int           fails = 0;
  bit           last_m = 1'b1;   // model: requester served most recently
  logic [W-1:0] data_m = '0;     // model: last delivered result

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in; flag means "result is zero".
  always_comb begin
    alu_out = '0;
    case (alu_op)
      5'h01:   alu_out = W'($signed(alu_a) + $signed(alu_b));
      5'h02:   alu_out = W'($signed(alu_a) - $signed(alu_b));
      5'h03:   alu_out = alu_a & alu_b;
      5'h04:   alu_out = alu_a | alu_b;
      5'h05:   alu_out = alu_a ^ alu_b;
      5'h06:   alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
    alu_flag = (alu_out == '0);
  end

  // Expected result of an operation as seen by the requester.
  function automatic logic [W-1:0] ref_res(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    if (op == 5'h01) return a + b;
    if (op == 5'h02) return a - b;
    if (op == 5'h03) return a & b;
    if (op == 5'h04) return a | b;
    if (op == 5'h05) return a ^ b;
    if (op == 5'h06) return ~(a | b);
    return '0;
  endfunction

  function automatic logic [4:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 5'(r);
    return 5'($urandom_range(7, 31));
  endfunction

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: present both requesters, predict the winner from the
  // round-robin rule, follow it through EXEC and RESP with 'delay' cycles of backpressure.
  // The losing requester stays valid throughout and must never see ready.
  task automatic serve(input bit v0, input logic [4:0] op0, input logic [W-1:0] a0,
                       input logic [W-1:0] b0,
                       input bit v1, input logic [4:0] op1, input logic [W-1:0] a1,
                       input logic [W-1:0] b1, input int delay);
    bit           w;
    bit           err_e;
    logic [4:0]   op_s, op_e;
    logic [W-1:0] a_s, b_s, res;
    w     = (v0 && v1) ? !last_m : v1;
    op_s  = w ? op1 : op0;
    a_s   = w ? a1 : a0;
    b_s   = w ? b1 : b0;
    err_e = (op_s > 5'h06);
    op_e  = err_e ? 5'h00 : op_s;
    res   = ref_res(op_e, a_s, b_s);

    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    @(negedge clk);
    check_b("idle_ready0", req0_ready, !w);
    check_b("idle_ready1", req1_ready, w);
    check_b("idle_rsp0_valid", rsp0_valid, 1'b0);
    check_b("idle_rsp1_valid", rsp1_valid, 1'b0);
    check_w("idle_rsp_data_hold", rsp_data, data_m);
    check_w("idle_alu_op", W'(alu_op), '0);
    step();

    @(negedge clk);
    check_w("exec_alu_op", W'(alu_op), W'(op_e));
    check_w("exec_alu_a", alu_a, a_s);
    check_w("exec_alu_b", alu_b, b_s);
    check_b("exec_ready0", req0_ready, 1'b0);
    check_b("exec_ready1", req1_ready, 1'b0);
    check_b("exec_rsp0_valid", rsp0_valid, 1'b0);
    check_b("exec_rsp1_valid", rsp1_valid, 1'b0);
    step();

    for (int d = 0; d <= delay; d++) begin
      rsp0_ready = w ? 1'b1 : (d == delay);
      rsp1_ready = w ? (d == delay) : 1'b1;
      @(negedge clk);
      check_b("resp_rsp0_valid", rsp0_valid, !w);
      check_b("resp_rsp1_valid", rsp1_valid, w);
      check_w("resp_data", rsp_data, res);
      check_b("resp_flag", rsp_flag, (res == '0));
      check_b("resp_err", rsp_err, err_e);
      check_b("resp_ready0", req0_ready, 1'b0);
      check_b("resp_ready1", req1_ready, 1'b0);
      check_w("resp_alu_a", alu_a, '0);
      check_w("resp_alu_op", W'(alu_op), '0);
      step();
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    last_m = w;
    data_m = res;
    $display("[TB] txn id=%0d op=%02h a=%08h b=%08h res=%08h err=%0b wait=%0d",
             w, op_s, a_s, b_s, res, err_e, delay);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_ready0"}, req0_ready, 1'b0);
    check_b({tag, "_ready1"}, req1_ready, 1'b0);
    check_b({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
    check_b({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
    check_w({tag, "_alu_a"}, alu_a, '0);
    check_w({tag, "_alu_b"}, alu_b, '0);
    check_w({tag, "_alu_op"}, W'(alu_op), '0);
    check_w({tag, "_rsp_data"}, rsp_data, '0);
    check_b({tag, "_rsp_flag"}, rsp_flag, 1'b0);
    check_b({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    last_m = 1'b1;
    data_m = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    step();
    apply_reset();

    // single ADD from requester 0
    serve(1'b1, 5'h01, 32'd5, 32'd7, 1'b0, 5'h00, '0, '0, 0);

    // backpressure: requester 1 SUB 3-10 held 4 cycles while requester 0 keeps asking
    serve(1'b1, 5'h03, 32'h0000_00FF, 32'h0000_0F0F, 1'b1, 5'h02, 32'd3, 32'd10, 4);
    // requester 0 then gets its turn
    serve(1'b1, 5'h03, 32'h0000_00FF, 32'h0000_0F0F, 1'b0, 5'h00, '0, '0, 0);

    // contention from reset and fairness over 6 back-to-back operations
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      serve(1'b1, 5'h01, $urandom, $urandom, 1'b1, 5'h05, $urandom, $urandom, i % 2);
    end

    // reset while in EXEC: everything returns to reset values at once, no response follows
    req0_valid = 1'b1; req0_op = 5'h04; req0_a = 32'h1234_0000; req0_b = 32'h0000_5678;
    req1_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midexec");
    req0_valid = 1'b0;
    step();
    rst_n = 1'b1;
    last_m = 1'b1;
    data_m = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_b("post_reset_rsp0_valid", rsp0_valid, 1'b0);
      check_b("post_reset_rsp1_valid", rsp1_valid, 1'b0);
      step();
    end
    serve(1'b0, 5'h00, '0, '0, 1'b1, 5'h06, 32'h0F0F_0000, 32'h0000_00F0, 1);

    // illegal opcode runs as NOP and reports an error
    serve(1'b1, 5'h1F, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 5'h00, '0, '0, 0);
    serve(1'b1, 5'h01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'h00, '0, '0, 0);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      bit rv0, rv1;
      rv0 = ($urandom_range(0, 1) == 1);
      rv1 = rv0 ? ($urandom_range(0, 1) == 1) : 1'b1;
      serve(rv0, rand_op(), $urandom, $urandom, rv1, rand_op(), $urandom, $urandom,
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
